adc_window_stats: RTL and testbench

//  Downstream consumer of the 12-bit serial ADC reader. Takes each completed

---
 rtl/adc_window_stats_pkg.sv | 14 +
 rtl/adc_window_stats_if.sv | 26 ++
 rtl/adc_window_stats_rise_detect.sv | 20 ++
 rtl/adc_window_stats.sv | 128 ++++++++++++
 tb/tb_adc_window_stats.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/adc_window_stats_pkg.sv
// Shared constants and FSM encoding for the ADC window statistics block.
// Also used by the ADC reader and the LED stage.
package adc_window_stats_pkg;

    localparam int ADC_DATA_W  = 12;
    localparam int WIN_COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

endpackage

// File: rtl/adc_window_stats_if.sv
// Sample-in / statistics-out bundle between the ADC reader side and the
// display/logging consumers.
interface adc_window_stats_if
    import adc_window_stats_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
);
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic                   clear;
    logic [DATA_W-1:0]      mean;
    logic [DATA_W-1:0]      min_val;
    logic [DATA_W-1:0]      max_val;
    logic                   out_valid;
    logic [WIN_COUNT_W-1:0] win_count;

    modport master (
        output in_ready, in_data, clear,
        input  mean, min_val, max_val, out_valid, win_count
    );

    modport slave (
        input  in_ready, in_data, clear,
        output mean, min_val, max_val, out_valid, win_count
    );
endinterface

// File: rtl/adc_window_stats_rise_detect.sv
// Single-bit rising-edge detector. The history flop resets low, so an input
// already high when reset is released produces one rise.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);
    logic sig_prev_q;
    logic sig_prev_d;

    always_comb sig_prev_d = sig_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sig_prev_q <= 1'b0;
        else          sig_prev_q <= sig_prev_d;
    end

    assign rise = sig_in & ~sig_prev_q;
endmodule

// File: rtl/adc_window_stats.sv
// Gathers 2**LOG2_WIN accepted ADC samples per window and publishes the
// truncated mean, minimum and maximum with a one-cycle out_valid strobe.
module adc_window_stats
    import adc_window_stats_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int LOG2_WIN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    adc_window_stats_if.slave bus
);
    localparam int ACC_W = DATA_W + LOG2_WIN;
    localparam int CNT_W = LOG2_WIN + 1;
    localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(1) << LOG2_WIN;

    logic                   accept;
    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic [DATA_W-1:0]      wmin_q, wmin_d;
    logic [DATA_W-1:0]      wmax_q, wmax_d;
    logic [DATA_W-1:0]      mean_q, mean_d;
    logic [DATA_W-1:0]      min_q, min_d;
    logic [DATA_W-1:0]      max_q, max_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIN_COUNT_W-1:0] win_count_q, win_count_d;
    logic                   seed;
    logic                   fold;

    rise_detect u_ready_rise (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (bus.in_ready),
        .rise    (accept)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        wmin_d      = wmin_q;
        wmax_d      = wmax_q;
        mean_d      = mean_q;
        min_d       = min_q;
        max_d       = max_q;
        out_valid_d = 1'b0;
        win_count_d = win_count_q;
        cnt_inc     = cnt_q + 1'b1;
        seed        = 1'b0;
        fold        = 1'b0;

        case (state_q)
            ST_EMPTY: seed = accept;
            ST_ACCUM: fold = accept;
            ST_PUBLISH: begin
                // Top DATA_W bits of the accumulator are the sum >> LOG2_WIN.
                mean_d      = acc_q[ACC_W-1 -: DATA_W];
                min_d       = wmin_q;
                max_d       = wmax_q;
                out_valid_d = 1'b1;
                win_count_d = win_count_q + 1'b1;
                state_d     = ST_EMPTY;
                cnt_d       = '0;
                seed        = accept;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (seed) begin
            acc_d   = ACC_W'(bus.in_data);
            wmin_d  = bus.in_data;
            wmax_d  = bus.in_data;
            cnt_d   = CNT_W'(1);
            state_d = (CNT_W'(1) == WIN_LEN) ? ST_PUBLISH : ST_ACCUM;
        end

        if (fold) begin
            acc_d = acc_q + ACC_W'(bus.in_data);
            if (bus.in_data < wmin_q) wmin_d = bus.in_data;
            if (bus.in_data > wmax_q) wmax_d = bus.in_data;
            cnt_d = cnt_inc;
            if (cnt_inc == WIN_LEN) state_d = ST_PUBLISH;
        end

        // Clear wins over a same-cycle sample but never touches published results.
        if (bus.clear) begin
            state_d = ST_EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
            wmin_d  = '0;
            wmax_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            wmin_q      <= '0;
            wmax_q      <= '0;
            mean_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            wmin_q      <= wmin_d;
            wmax_q      <= wmax_d;
            mean_q      <= mean_d;
            min_q       <= min_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            win_count_q <= win_count_d;
        end
    end

    assign bus.mean      = mean_q;
    assign bus.min_val   = min_q;
    assign bus.max_val   = max_q;
    assign bus.out_valid = out_valid_q;
    assign bus.win_count = win_count_q;
endmodule

// File: tb/tb_adc_window_stats.sv
// Directed bench: a 4-sample-window instance (b2) and a default 16-sample
// instance (b4) share clock and reset.
module tb_adc_window_stats;
    import adc_window_stats_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    adc_window_stats_if b2 ();
    adc_window_stats_if b4 ();

    adc_window_stats #(.LOG2_WIN(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
    adc_window_stats                 dut4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    int checks  = 0;
    int passed  = 0;
    int failed  = 0;
    int strobes4 = 0;
    int s0;

    always @(posedge clk) begin
        if (b4.out_valid) strobes4 <= strobes4 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse2(input logic [11:0] v);
        b2.in_data = v; b2.in_ready = 1'b1; @(negedge clk); b2.in_ready = 1'b0;
    endtask
    task automatic send2(input logic [11:0] v);
        pulse2(v); @(negedge clk);
    endtask
    task automatic pulse4(input logic [11:0] v);
        b4.in_data = v; b4.in_ready = 1'b1; @(negedge clk); b4.in_ready = 1'b0;
    endtask
    task automatic send4(input logic [11:0] v);
        pulse4(v); @(negedge clk);
    endtask

    task automatic expect2(input string tag, input int m, input int mn, input int mx, input int wc);
        chk({tag, ".valid"}, b2.out_valid, 1);
        chk({tag, ".mean"},  b2.mean,      m);
        chk({tag, ".min"},   b2.min_val,   mn);
        chk({tag, ".max"},   b2.max_val,   mx);
        chk({tag, ".wcnt"},  b2.win_count, wc);
    endtask
    task automatic expect4(input string tag, input int m, input int mn, input int mx, input int wc);
        chk({tag, ".valid"}, b4.out_valid, 1);
        chk({tag, ".mean"},  b4.mean,      m);
        chk({tag, ".min"},   b4.min_val,   mn);
        chk({tag, ".max"},   b4.max_val,   mx);
        chk({tag, ".wcnt"},  b4.win_count, wc);
    endtask
    task automatic zeros(input string tag);
        chk({tag, ".b2.mean"},  b2.mean, 0);      chk({tag, ".b2.min"}, b2.min_val, 0);
        chk({tag, ".b2.max"},   b2.max_val, 0);   chk({tag, ".b2.valid"}, b2.out_valid, 0);
        chk({tag, ".b2.wcnt"},  b2.win_count, 0);
        chk({tag, ".b4.mean"},  b4.mean, 0);      chk({tag, ".b4.min"}, b4.min_val, 0);
        chk({tag, ".b4.max"},   b4.max_val, 0);   chk({tag, ".b4.valid"}, b4.out_valid, 0);
        chk({tag, ".b4.wcnt"},  b4.win_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        b2.in_ready = 1'b0; b2.in_data = '0; b2.clear = 1'b0;
        b4.in_ready = 1'b0; b4.in_data = '0; b4.clear = 1'b0;
        repeat (2) @(negedge clk);
        zeros("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Basic 4-sample window with exact strobe timing.
        send2(100); send2(200); send2(300); pulse2(401);
        chk("t1.early_valid", b2.out_valid, 0);
        chk("t1.early_mean", b2.mean, 0);
        @(negedge clk);
        expect2("t1", 250, 100, 401, 1);
        @(negedge clk);
        chk("t1.one_cycle", b2.out_valid, 0);
        chk("t1.hold_mean", b2.mean, 250);
        $display("t1 window 100,200,300,401 done");

        // Full-scale and all-zero 16-sample windows.
        for (int i = 0; i < 16; i++) send4(12'd4095);
        expect4("t2a", 4095, 4095, 4095, 1);
        for (int i = 0; i < 16; i++) send4(12'd0);
        expect4("t2b", 0, 0, 0, 2);
        $display("t2 full-scale and zero windows done");

        // Held level gives a single accept; spaced pulses each give one.
        @(negedge clk);
        s0 = strobes4;
        b4.in_data = 12'd7; b4.in_ready = 1'b1;
        repeat (50) @(negedge clk);
        b4.in_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            pulse4(12'd23);
            if (i < 14) repeat (13) @(negedge clk);
        end
        chk("t3.no_early_strobe", strobes4 - s0, 0);
        @(negedge clk);
        expect4("t3", 22, 7, 23, 3);
        $display("t3 level hold and spaced pulses done");

        // Clear together with a sample drops it and restarts the window.
        send2(1000); send2(2000);
        b2.clear = 1'b1; b2.in_data = 12'd3000; b2.in_ready = 1'b1;
        @(negedge clk);
        b2.clear = 1'b0; b2.in_ready = 1'b0;
        @(negedge clk);
        chk("t4.clear_hold_mean", b2.mean, 250);
        send2(10); send2(20); send2(30); pulse2(40);
        chk("t4.pre_valid", b2.out_valid, 0);
        chk("t4.pre_mean", b2.mean, 250);
        chk("t4.pre_max", b2.max_val, 401);
        @(negedge clk);
        expect2("t4", 25, 10, 40, 2);

        // Clear during the publish cycle still publishes.
        send2(5); send2(6); send2(7); pulse2(9);
        b2.clear = 1'b1;
        @(negedge clk);
        b2.clear = 1'b0;
        expect2("t4c", 6, 5, 9, 3);
        send2(50); send2(60); send2(70); send2(80);
        expect2("t4d", 65, 50, 80, 4);
        $display("t4 clear cases done");

        // Asynchronous reset mid-window; b4 ready already high at release.
        send2(1000); send2(2000);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 zeros("t6.async");
        b4.in_data = 12'd16; b4.in_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        b4.in_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) send4(12'd0);
        expect4("t6.b4", 1, 0, 16, 1);
        send2(10); send2(20); send2(30); send2(40);
        expect2("t6.b2", 25, 10, 40, 1);
        $display("t6 async reset done");

        // Windows at the maximum accept rate, then win_count wrap.
        send2(4); send2(8); send2(12); send2(16);
        expect2("t5a", 10, 4, 16, 2);
        send2(1); send2(2); send2(3); send2(5);
        expect2("t5b", 2, 1, 5, 3);
        for (int w = 0; w < 252; w++) begin
            for (int k = 0; k < 4; k++) send2(12'(w + k));
        end
        chk("t5.wcnt255", b2.win_count, 255);
        send2(0); send2(1); send2(2); send2(3);
        expect2("t5wrap", 1, 0, 3, 0);
        $display("t5 back-to-back windows and wrap done");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
